// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one pipeline request at a time to a single memory port.
// Macro LSU_MISALIGN_EN: misaligned half/word requests are split into byte accesses instead of faulting.
module lsu_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_ctrl,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_fault,
  output logic [DATA_WIDTH-1:0] mem_A,
  output logic                  mem_WE,
  output logic [2:0]            mem_ctrl,
  output logic [DATA_WIDTH-1:0] mem_WD,
  input  logic [DATA_WIDTH-1:0] mem_RD
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd3
`ifdef LSU_MISALIGN_EN
    , ST_BYTES = 2'd2
`endif
  } state_t;

  state_t                state_r;
  logic                  req_ready_r;
  logic                  rsp_valid_r;
  logic                  rsp_fault_r;
  logic [DATA_WIDTH-1:0] rsp_rdata_r;
  logic [DATA_WIDTH-1:0] mem_a_r;
  logic                  mem_we_r;
  logic [2:0]            mem_ctrl_r;
  logic [DATA_WIDTH-1:0] mem_wd_r;
  logic                  we_r;
  logic [2:0]            ctrl_r;
  logic                  misalign_s;

`ifdef LSU_MISALIGN_EN
  logic [DATA_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic [1:0]            cnt_r;
  logic [1:0]            next_cnt_s;
  logic                  last_s;
  logic [DATA_WIDTH-1:0] bytes_data_s;
  logic [7:0]            next_byte_s;
  logic [DATA_WIDTH-1:0] byte_addr_s;
`endif

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_fault = rsp_fault_r;
  assign rsp_rdata = rsp_rdata_r;
  assign mem_A     = mem_a_r;
  assign mem_WE    = mem_we_r;
  assign mem_ctrl  = mem_ctrl_r;
  assign mem_WD    = mem_wd_r;

  // Size/sign extension of LSB-aligned load data.
  function automatic logic [DATA_WIDTH-1:0] ext_load(input logic [DATA_WIDTH-1:0] d,
                                                     input logic [2:0] c);
    logic [DATA_WIDTH-1:0] r;
    case (c[1:0])
      2'b00:   r = c[2] ? {{(DATA_WIDTH-8){1'b0}}, d[7:0]} : {{(DATA_WIDTH-8){d[7]}}, d[7:0]};
      2'b01:   r = c[2] ? {{(DATA_WIDTH-16){1'b0}}, d[15:0]} : {{(DATA_WIDTH-16){d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Alignment check of the incoming request.
  always_comb begin
    misalign_s = 1'b0;
    case (req_ctrl[1:0])
      2'b01:   misalign_s = req_addr[0];
      2'b10:   misalign_s = (req_addr[1:0] != 2'b00);
      default: misalign_s = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_EN
  // Byte-sequence helpers: merged load lanes and the next byte/address to present.
  always_comb begin
    next_cnt_s   = cnt_r + 2'd1;
    last_s       = (ctrl_r[1:0] == 2'b01) ? (cnt_r == 2'd1) : (cnt_r == 2'd3);
    bytes_data_s = data_r;
    bytes_data_s[{cnt_r, 3'b000} +: 8] = mem_RD[7:0];
    next_byte_s  = wdata_r[{next_cnt_s, 3'b000} +: 8];
    byte_addr_s  = addr_r + {{(DATA_WIDTH-2){1'b0}}, next_cnt_s};
  end
`endif

  // Request/response FSM with registered memory-port and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_fault_r <= 1'b0;
      rsp_rdata_r <= {DATA_WIDTH{1'b0}};
      mem_a_r     <= {DATA_WIDTH{1'b0}};
      mem_we_r    <= 1'b0;
      mem_ctrl_r  <= 3'b000;
      mem_wd_r    <= {DATA_WIDTH{1'b0}};
      we_r        <= 1'b0;
      ctrl_r      <= 3'b000;
`ifdef LSU_MISALIGN_EN
      addr_r      <= {DATA_WIDTH{1'b0}};
      wdata_r     <= {DATA_WIDTH{1'b0}};
      data_r      <= {DATA_WIDTH{1'b0}};
      cnt_r       <= 2'd0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            we_r        <= req_we;
            ctrl_r      <= req_ctrl;
            req_ready_r <= 1'b0;
`ifdef LSU_MISALIGN_EN
            addr_r      <= req_addr;
            wdata_r     <= req_wdata;
`endif
            if (req_ctrl[1:0] == 2'b11) begin
              state_r     <= ST_RESP;
              rsp_valid_r <= 1'b1;
              rsp_fault_r <= 1'b1;
              rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            end else if (misalign_s) begin
`ifdef LSU_MISALIGN_EN
              state_r    <= ST_BYTES;
              cnt_r      <= 2'd0;
              data_r     <= {DATA_WIDTH{1'b0}};
              mem_a_r    <= req_addr;
              mem_ctrl_r <= 3'b100;
              mem_wd_r   <= {{(DATA_WIDTH-8){1'b0}}, req_wdata[7:0]};
              mem_we_r   <= req_we;
`else
              state_r     <= ST_RESP;
              rsp_valid_r <= 1'b1;
              rsp_fault_r <= 1'b1;
              rsp_rdata_r <= {DATA_WIDTH{1'b0}};
`endif
            end else begin
              state_r    <= ST_ACCESS;
              mem_a_r    <= req_addr;
              mem_ctrl_r <= req_ctrl;
              mem_wd_r   <= req_wdata;
              mem_we_r   <= req_we;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          state_r     <= ST_RESP;
          rsp_valid_r <= 1'b1;
          rsp_fault_r <= 1'b0;
          rsp_rdata_r <= we_r ? {DATA_WIDTH{1'b0}} : ext_load(mem_RD, ctrl_r);
          mem_a_r     <= {DATA_WIDTH{1'b0}};
          mem_we_r    <= 1'b0;
          mem_ctrl_r  <= 3'b000;
          mem_wd_r    <= {DATA_WIDTH{1'b0}};
        end
`ifdef LSU_MISALIGN_EN
        ST_BYTES: begin
          data_r <= bytes_data_s;
          if (last_s) begin
            state_r     <= ST_RESP;
            cnt_r       <= 2'd0;
            rsp_valid_r <= 1'b1;
            rsp_fault_r <= 1'b0;
            rsp_rdata_r <= we_r ? {DATA_WIDTH{1'b0}} : ext_load(bytes_data_s, ctrl_r);
            mem_a_r     <= {DATA_WIDTH{1'b0}};
            mem_we_r    <= 1'b0;
            mem_ctrl_r  <= 3'b000;
            mem_wd_r    <= {DATA_WIDTH{1'b0}};
          end else begin
            cnt_r    <= next_cnt_s;
            mem_a_r  <= byte_addr_s;
            mem_wd_r <= {{(DATA_WIDTH-8){1'b0}}, next_byte_s};
          end
        end
`endif
        ST_RESP: begin
          if (rsp_ready) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_fault_r <= 1'b0;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
          rsp_fault_r <= 1'b0;
          mem_we_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized self-checking bench for lsu_ctrl against a byte-array reference memory.
module tb_lsu_ctrl;
`ifdef LSU_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_ctrl = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] mem_A;
  logic        mem_WE;
  logic [2:0]  mem_ctrl;
  logic [31:0] mem_WD;
  logic [31:0] mem_RD;

  logic [7:0] env_mem [0:1023] = '{default: 8'h00};
  logic [7:0] gold    [0:1023] = '{default: 8'h00};
  int n_checks = 0;
  int n_fail   = 0;

  lsu_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_A(mem_A), .mem_WE(mem_WE), .mem_ctrl(mem_ctrl), .mem_WD(mem_WD), .mem_RD(mem_RD)
  );

  always #5 clk = ~clk;

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  // Memory seen by the DUT: LSB-aligned, zero-filled combinational read.
  always_comb begin
    mem_RD = 32'h0;
    for (int k = 0; k < 4; k++)
      if (k < nbytes(mem_ctrl[1:0])) mem_RD[8*k +: 8] = env_mem[10'(mem_A + 32'(k))];
  end

  always @(posedge clk) begin
    if (mem_WE)
      for (int k = 0; k < 4; k++)
        if (k < nbytes(mem_ctrl[1:0])) env_mem[10'(mem_A + 32'(k))] <= mem_WD[8*k +: 8];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] gold_load(input logic [31:0] addr, input logic [2:0] ctrl);
    logic [31:0] v;
    logic signed [7:0] sb;
    logic signed [15:0] sh;
    v = 32'h0;
    for (int k = 0; k < nbytes(ctrl[1:0]); k++) v[8*k +: 8] = gold[10'(addr + 32'(k))];
    sb = v[7:0];
    sh = v[15:0];
    case (ctrl[1:0])
      2'b00:   return ctrl[2] ? {24'h0, v[7:0]} : int'(sb);
      2'b01:   return ctrl[2] ? {16'h0, v[15:0]} : int'(sh);
      default: return v;
    endcase
  endfunction

  task automatic xact(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                      input logic [31:0] wdata, input int hold);
    int n, cyc, we_cnt, exp_lat, exp_we;
    bit misal, exp_fault;
    logic [31:0] exp_rd;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    n = nbytes(ctrl[1:0]);
    misal = ((ctrl[1:0] == 2'b01) && addr[0]) || ((ctrl[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    exp_fault = (ctrl[1:0] == 2'b11) || (misal && !MIS_EN);
    exp_lat = exp_fault ? 1 : (misal ? n + 1 : 2);
    exp_we = (exp_fault || !we) ? 0 : (misal ? n : 1);
    exp_rd = (exp_fault || we) ? 32'h0 : gold_load(addr, ctrl);
    if (!exp_fault && we)
      for (int k = 0; k < n; k++) gold[10'(addr + 32'(k))] = wdata[8*k +: 8];
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_ctrl = ctrl; req_addr = addr; req_wdata = wdata;
    check_eq("req_ready_idle", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; we_cnt = 0;
    while (cyc < 20) begin
      if (mem_WE) begin
        we_cnt++; wa.push_back(mem_A); wd.push_back(mem_WD);
      end
      if (rsp_valid) break;
      @(negedge clk);
      cyc++;
    end
    check_eq("latency", 32'(cyc), 32'(exp_lat));
    check_eq("rsp_fault", {31'h0, rsp_fault}, {31'h0, exp_fault});
    check_eq("rsp_rdata", rsp_rdata, exp_rd);
    check_eq("mem_we_cycles", 32'(we_cnt), 32'(exp_we));
    check_eq("mem_idle_in_resp", {31'h0, (mem_WE | (|mem_A) | (|mem_WD) | (|mem_ctrl))}, 32'h0);
    for (int k = 0; k < wa.size(); k++) begin
      check_eq("store_addr", wa[k], addr + 32'(k));
      check_eq("store_data", wd[k], misal ? {24'h0, wdata[8*k +: 8]} : wdata);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_valid", {31'h0, rsp_valid}, 32'h1);
      check_eq("hold_rdata", rsp_rdata, exp_rd);
      check_eq("hold_req_ready", {31'h0, req_ready}, 32'h0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("rsp_valid_drop", {31'h0, rsp_valid}, 32'h0);
    check_eq("req_ready_back", {31'h0, req_ready}, 32'h1);
  endtask

  task automatic reset_in_resp();
    int cyc;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_ctrl = 3'b010; req_addr = 32'h100; req_wdata = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("rir_reached_resp", {31'h0, rsp_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("rir_valid_async", {31'h0, rsp_valid}, 32'h0);
    check_eq("rir_rdata_async", rsp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rir_req_ready", {31'h0, req_ready}, 32'h1);
  endtask

`ifdef LSU_MISALIGN_EN
  task automatic reset_in_bytes();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_ctrl = 3'b010; req_addr = 32'h201; req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("rib_we_c1", {31'h0, mem_WE}, 32'h1);
    @(negedge clk);
    check_eq("rib_we_c2", {31'h0, mem_WE}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("rib_we_async", {31'h0, mem_WE}, 32'h0);
    gold[10'h201] = 8'h0D;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rib_no_rsp", {31'h0, rsp_valid}, 32'h0);
    check_eq("rib_idle", {31'h0, req_ready}, 32'h1);
    xact(1'b0, 3'b100, 32'h201, 32'h0, 0);
    xact(1'b0, 3'b100, 32'h202, 32'h0, 0);
  endtask
`endif

  initial begin
    logic [2:0] c;
    int r;
    repeat (2) @(negedge clk);
    check_eq("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check_eq("rst_rsp_fault", {31'h0, rsp_fault}, 32'h0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
    check_eq("rst_mem_port", {31'h0, (mem_WE | (|mem_A) | (|mem_WD) | (|mem_ctrl))}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_req_ready", {31'h0, req_ready}, 32'h1);

    xact(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0);
    xact(1'b0, 3'b010, 32'h100, 32'h0, 0);
    xact(1'b1, 3'b000, 32'h10, 32'h80, 0);
    xact(1'b0, 3'b000, 32'h10, 32'h0, 0);
    xact(1'b0, 3'b100, 32'h10, 32'h0, 0);
    xact(1'b0, 3'b001, 32'h103, 32'h0, 0);
    xact(1'b1, 3'b011, 32'h100, 32'h12345678, 0);
    xact(1'b0, 3'b111, 32'h100, 32'h0, 0);
    xact(1'b0, 3'b010, 32'h100, 32'h0, 3);
`ifdef LSU_MISALIGN_EN
    xact(1'b1, 3'b010, 32'h101, 32'h11223344, 0);
    xact(1'b0, 3'b010, 32'h101, 32'h0, 0);
    xact(1'b1, 3'b010, 32'hFFFFFFFE, 32'hA1B2C3D4, 0);
    xact(1'b0, 3'b001, 32'h103, 32'h0, 1);
    reset_in_bytes();
`endif
    reset_in_resp();

    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 9);
      c[1:0] = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      c[2] = 1'($urandom_range(0, 1));
      xact(1'($urandom_range(0, 1)), c, 32'h100 + 32'($urandom_range(0, 63)), $urandom,
           $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
